// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipelined RV32I control unit.
// Holds the RV32I major opcodes, the ALU operation and forwarding-select
// encodings, the per-stage control record (ctrl_t) with its bubble value,
// and the forwarding-select helper used for both ALU sources.
package pipe_pkg;

  localparam int CTRL_ALU_W   = 4;
  localparam int CTRL_RADDR_W = 5;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I_ALU  = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  typedef enum logic [CTRL_ALU_W-1:0] {
    ALU_ADD   = 4'd0,
    ALU_SUB   = 4'd1,
    ALU_SLL   = 4'd2,
    ALU_SLT   = 4'd3,
    ALU_SLTU  = 4'd4,
    ALU_XOR   = 4'd5,
    ALU_SRL   = 4'd6,
    ALU_SRA   = 4'd7,
    ALU_OR    = 4'd8,
    ALU_AND   = 4'd9,
    ALU_PASSB = 4'd10
  } alu_op_e;

  typedef enum logic [1:0] {
    FWD_REGFILE = 2'b00,
    FWD_EX_MEM  = 2'b01,
    FWD_MEM_WB  = 2'b10
  } fwd_sel_e;

  typedef struct packed {
    logic                    reg_we;
    logic [CTRL_RADDR_W-1:0] rd;
    logic [CTRL_RADDR_W-1:0] rs1;
    logic [CTRL_RADDR_W-1:0] rs2;
    logic                    mem_rd;
    logic                    mem_wr;
    logic                    src1_pc;
    logic                    src2_imm;
    alu_op_e                 alu_ctrl;
    logic                    illegal;
  } ctrl_t;

  localparam ctrl_t CTRL_BUBBLE = '{
    reg_we:   1'b0,
    rd:       '0,
    rs1:      '0,
    rs2:      '0,
    mem_rd:   1'b0,
    mem_wr:   1'b0,
    src1_pc:  1'b0,
    src2_imm: 1'b0,
    alu_ctrl: ALU_ADD,
    illegal:  1'b0
  };

  // The younger producer (EX/MEM) wins over MEM/WB; x0 is never forwarded.
  function automatic fwd_sel_e fwd_pick(input logic [CTRL_RADDR_W-1:0] rs,
                                        input ctrl_t ex_mem,
                                        input ctrl_t mem_wb);
    if (ex_mem.reg_we && ex_mem.rd != '0 && ex_mem.rd == rs)
      return FWD_EX_MEM;
    else if (mem_wb.reg_we && mem_wb.rd != '0 && mem_wb.rd == rs)
      return FWD_MEM_WB;
    else
      return FWD_REGFILE;
  endfunction

endpackage

// File: rtl/pipe_decode.sv
// Combinational ID-stage decoder.
// Ports:
//   instr - 32-bit instruction in ID
//   ctrl  - decoded control record; unknown opcodes yield a bubble with
//           illegal set. Unused rs fields are 0, reg_we is 0 when rd is x0.
module pipe_decode
  import pipe_pkg::*;
(
  input  logic [31:0] instr,
  output ctrl_t       ctrl
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       funct7_b5;
  logic [CTRL_RADDR_W-1:0] rd_f, rs1_f, rs2_f;
  alu_op_e    alu_f3;

  assign opcode    = instr[6:0];
  assign rd_f      = instr[11:7];
  assign funct3    = instr[14:12];
  assign rs1_f     = instr[19:15];
  assign rs2_f     = instr[24:20];
  assign funct7_b5 = instr[30];

  // Immediate bits belong to the datapath, not to control.
  logic unused_instr_bits;
  assign unused_instr_bits = ^instr;

  // funct3 mapping shared by R-type and I-ALU; the SUB case is patched
  // below because I-ALU never subtracts.
  always_comb begin
    unique case (funct3)
      3'b000:  alu_f3 = funct7_b5 ? ALU_SUB : ALU_ADD;
      3'b001:  alu_f3 = ALU_SLL;
      3'b010:  alu_f3 = ALU_SLT;
      3'b011:  alu_f3 = ALU_SLTU;
      3'b100:  alu_f3 = ALU_XOR;
      3'b101:  alu_f3 = funct7_b5 ? ALU_SRA : ALU_SRL;
      3'b110:  alu_f3 = ALU_OR;
      default: alu_f3 = ALU_AND;
    endcase
  end

  always_comb begin
    // NOTE: every field gets a default first so no path through the case
    // can leave a field unassigned and infer a latch.
    ctrl = CTRL_BUBBLE;
    unique case (opcode)
      OP_R: begin
        ctrl.reg_we = 1'b1; ctrl.rd = rd_f; ctrl.rs1 = rs1_f; ctrl.rs2 = rs2_f;
        ctrl.alu_ctrl = alu_f3;
      end
      OP_I_ALU: begin
        ctrl.reg_we = 1'b1; ctrl.rd = rd_f; ctrl.rs1 = rs1_f;
        ctrl.src2_imm = 1'b1;
        ctrl.alu_ctrl = (funct3 == 3'b000) ? ALU_ADD : alu_f3;
      end
      OP_LOAD: begin
        ctrl.reg_we = 1'b1; ctrl.rd = rd_f; ctrl.rs1 = rs1_f;
        ctrl.src2_imm = 1'b1; ctrl.mem_rd = 1'b1;
      end
      OP_STORE: begin
        ctrl.rs1 = rs1_f; ctrl.rs2 = rs2_f;
        ctrl.src2_imm = 1'b1; ctrl.mem_wr = 1'b1;
      end
      OP_BRANCH: begin
        ctrl.rs1 = rs1_f; ctrl.rs2 = rs2_f;
        ctrl.alu_ctrl = ALU_SUB;
      end
      OP_JAL: begin
        ctrl.reg_we = 1'b1; ctrl.rd = rd_f;
        ctrl.src1_pc = 1'b1; ctrl.src2_imm = 1'b1;
      end
      OP_JALR: begin
        ctrl.reg_we = 1'b1; ctrl.rd = rd_f; ctrl.rs1 = rs1_f;
        ctrl.src1_pc = 1'b1; ctrl.src2_imm = 1'b1;
      end
      OP_AUIPC: begin
        ctrl.reg_we = 1'b1; ctrl.rd = rd_f;
        ctrl.src1_pc = 1'b1; ctrl.src2_imm = 1'b1;
      end
      OP_LUI: begin
        ctrl.reg_we = 1'b1; ctrl.rd = rd_f;
        ctrl.src2_imm = 1'b1; ctrl.alu_ctrl = ALU_PASSB;
      end
      default: ctrl.illegal = 1'b1;
    endcase
    // Writes to x0 are architecturally discarded; dropping them here keeps
    // them out of hazard and forwarding logic.
    if (ctrl.rd == '0) ctrl.reg_we = 1'b0;
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipelined control unit for the 5-stage RV32I core.
// Decodes ID, carries control through ID/EX, EX/MEM, MEM/WB, and produces
// load-use stall, branch flush and ALU forwarding selects.
// Ports:
//   clk, rst          - clock, synchronous active-high reset
//   id_valid/id_instr - ID-stage instruction
//   ex_branch_taken   - EX resolved a taken control transfer
//   stall, flush      - combinational hazard controls for PC and IF/ID
//   ex_*              - ALU control, source and forward selects (ID/EX)
//   mem_rd_en/wr_en   - data-memory enables (EX/MEM)
//   wb_*              - register write controls (MEM/WB)
module pipe_ctrl
  import pipe_pkg::*;
#(
  parameter int ALU_CTRL_W = 4,
  parameter int RADDR_W    = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  id_valid,
  input  logic [31:0]           id_instr,
  input  logic                  ex_branch_taken,
  output logic                  stall,
  output logic                  flush,
  output logic [ALU_CTRL_W-1:0] ex_alu_ctrl,
  output logic                  ex_src1_pc,
  output logic                  ex_src2_imm,
  output logic [1:0]            ex_fwd1_sel,
  output logic [1:0]            ex_fwd2_sel,
  output logic                  ex_illegal,
  output logic                  mem_rd_en,
  output logic                  mem_wr_en,
  output logic                  wb_reg_we,
  output logic [RADDR_W-1:0]    wb_rd,
  output logic                  wb_from_mem
);

  ctrl_t id_dec, id_ex, ex_mem, mem_wb;
  logic  load_use;

  pipe_decode u_decode (
    .instr (id_instr),
    .ctrl  (id_dec)
  );

  // Unused rs fields decode to 0 and a hazarding load has rd != 0, so an
  // unused source can never match.
  assign load_use = id_ex.mem_rd && (id_ex.rd != '0) &&
                    ((id_dec.rs1 == id_ex.rd) || (id_dec.rs2 == id_ex.rd));
  assign flush    = ex_branch_taken;
  assign stall    = load_use && id_valid && !flush;

  always_ff @(posedge clk) begin
    // NOTE: pipeline state uses non-blocking assignments so each stage
    // samples the previous stage's value from before this edge.
    if (rst) begin
      id_ex  <= CTRL_BUBBLE;
      ex_mem <= CTRL_BUBBLE;
      mem_wb <= CTRL_BUBBLE;
    end else begin
      if (flush || stall || !id_valid) id_ex <= CTRL_BUBBLE;
      else                             id_ex <= id_dec;
      ex_mem <= id_ex;
      mem_wb <= ex_mem;
    end
  end

  assign ex_fwd1_sel = fwd_pick(id_ex.rs1, ex_mem, mem_wb);
  assign ex_fwd2_sel = fwd_pick(id_ex.rs2, ex_mem, mem_wb);

  assign ex_alu_ctrl = ALU_CTRL_W'(id_ex.alu_ctrl);
  assign ex_src1_pc  = id_ex.src1_pc;
  assign ex_src2_imm = id_ex.src2_imm;
  assign ex_illegal  = id_ex.illegal;
  assign mem_rd_en   = ex_mem.mem_rd;
  assign mem_wr_en   = ex_mem.mem_wr;
  assign wb_reg_we   = mem_wb.reg_we;
  assign wb_rd       = RADDR_W'(mem_wb.rd);
  assign wb_from_mem = mem_wb.mem_rd;

  // Later stages carry the full record; only some fields drive outputs.
  logic unused_stage_bits;
  assign unused_stage_bits = ^{ex_mem, mem_wb};

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: forwarding, load-use stall, flush priority,
// x0 writes, illegal opcode and mid-stream reset.
module tb_pipe_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid;
  logic [31:0] id_instr;
  logic        ex_branch_taken;
  logic        stall, flush;
  logic [3:0]  ex_alu_ctrl;
  logic        ex_src1_pc, ex_src2_imm;
  logic [1:0]  ex_fwd1_sel, ex_fwd2_sel;
  logic        ex_illegal, mem_rd_en, mem_wr_en;
  logic        wb_reg_we, wb_from_mem;
  logic [4:0]  wb_rd;

  int total = 0;
  int bad   = 0;

  localparam logic [31:0] I_ADD_X3  = 32'h002081B3; // add  x3,x1,x2
  localparam logic [31:0] I_SUB_X5  = 32'h404182B3; // sub  x5,x3,x4
  localparam logic [31:0] I_NOP     = 32'h00000013; // addi x0,x0,0
  localparam logic [31:0] I_LW_X6   = 32'h0000A303; // lw   x6,0(x1)
  localparam logic [31:0] I_ADD_X7  = 32'h002303B3; // add  x7,x6,x2
  localparam logic [31:0] I_ADDI_X0 = 32'h00508013; // addi x0,x1,5
  localparam logic [31:0] I_ADD_X9  = 32'h001004B3; // add  x9,x0,x1
  localparam logic [31:0] I_BAD     = 32'h0000007F;

  pipe_ctrl dut (
    .clk             (clk),
    .rst             (rst),
    .id_valid        (id_valid),
    .id_instr        (id_instr),
    .ex_branch_taken (ex_branch_taken),
    .stall           (stall),
    .flush           (flush),
    .ex_alu_ctrl     (ex_alu_ctrl),
    .ex_src1_pc      (ex_src1_pc),
    .ex_src2_imm     (ex_src2_imm),
    .ex_fwd1_sel     (ex_fwd1_sel),
    .ex_fwd2_sel     (ex_fwd2_sel),
    .ex_illegal      (ex_illegal),
    .mem_rd_en       (mem_rd_en),
    .mem_wr_en       (mem_wr_en),
    .wb_reg_we       (wb_reg_we),
    .wb_rd           (wb_rd),
    .wb_from_mem     (wb_from_mem)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; outputs are then sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] instr);
    id_valid = v;
    id_instr = instr;
    #1;
  endtask

  task automatic check_all_bubble(input string tag);
    check({tag, ".stall"},   32'(stall), 0);
    check({tag, ".flush"},   32'(flush), 0);
    check({tag, ".alu"},     32'(ex_alu_ctrl), 0);
    check({tag, ".src1pc"},  32'(ex_src1_pc), 0);
    check({tag, ".src2imm"}, 32'(ex_src2_imm), 0);
    check({tag, ".fwd1"},    32'(ex_fwd1_sel), 0);
    check({tag, ".fwd2"},    32'(ex_fwd2_sel), 0);
    check({tag, ".illegal"}, 32'(ex_illegal), 0);
    check({tag, ".mem_rd"},  32'(mem_rd_en), 0);
    check({tag, ".mem_wr"},  32'(mem_wr_en), 0);
    check({tag, ".wb_we"},   32'(wb_reg_we), 0);
    check({tag, ".wb_rd"},   32'(wb_rd), 0);
    check({tag, ".wb_mem"},  32'(wb_from_mem), 0);
  endtask

  task automatic drain();
    drive(1'b0, I_NOP);
    for (int i = 0; i < 3; i++) tick();
  endtask

  initial begin
    rst = 1'b1; id_valid = 1'b0; id_instr = '0; ex_branch_taken = 1'b0;
    tick(); tick();
    rst = 1'b0;
    #1;
    check_all_bubble("reset");

    // add then dependent sub back to back: EX/MEM forward
    drive(1'b1, I_ADD_X3); tick();
    check("add.alu", 32'(ex_alu_ctrl), 0);
    check("add.src2imm", 32'(ex_src2_imm), 0);
    drive(1'b1, I_SUB_X5); tick();
    check("sub.alu", 32'(ex_alu_ctrl), 1);
    check("sub.fwd1_exmem", 32'(ex_fwd1_sel), 2'b01);
    check("sub.fwd2", 32'(ex_fwd2_sel), 2'b00);
    drive(1'b0, I_NOP); tick();
    check("add.wb_we", 32'(wb_reg_we), 1);
    check("add.wb_rd", 32'(wb_rd), 3);
    check("add.wb_mem", 32'(wb_from_mem), 0);
    drain();

    // one NOP between producer and consumer: MEM/WB forward
    drive(1'b1, I_ADD_X3); tick();
    drive(1'b1, I_NOP);    tick();
    drive(1'b1, I_SUB_X5); tick();
    check("sub_gap.fwd1_memwb", 32'(ex_fwd1_sel), 2'b10);
    drain();

    // load-use: exactly one stall, then MEM/WB forward
    drive(1'b1, I_LW_X6); tick();
    check("lw.src2imm", 32'(ex_src2_imm), 1);
    drive(1'b1, I_ADD_X7);
    check("lu.stall", 32'(stall), 1);
    check("lu.flush", 32'(flush), 0);
    tick();
    check("lu.bubble_stall", 32'(stall), 0);
    check("lu.bubble_alu", 32'(ex_alu_ctrl), 0);
    check("lu.bubble_src2", 32'(ex_src2_imm), 0);
    check("lw.mem_rd", 32'(mem_rd_en), 1);
    tick();
    check("lu.add_fwd1", 32'(ex_fwd1_sel), 2'b10);
    check("lu.add_fwd2", 32'(ex_fwd2_sel), 2'b00);
    check("lw.wb_mem", 32'(wb_from_mem), 1);
    check("lw.wb_we", 32'(wb_reg_we), 1);
    check("lw.wb_rd", 32'(wb_rd), 6);
    check("lu.mem_rd_bubble", 32'(mem_rd_en), 0);
    drain();

    // flush dominates stall
    drive(1'b1, I_LW_X6); tick();
    ex_branch_taken = 1'b1;
    drive(1'b1, I_ADD_X7);
    check("fl.flush", 32'(flush), 1);
    check("fl.stall", 32'(stall), 0);
    tick();
    ex_branch_taken = 1'b0;
    drive(1'b0, I_NOP);
    check("fl.alu", 32'(ex_alu_ctrl), 0);
    check("fl.src1pc", 32'(ex_src1_pc), 0);
    check("fl.src2imm", 32'(ex_src2_imm), 0);
    check("fl.illegal", 32'(ex_illegal), 0);
    tick();
    check("fl.mem_rd", 32'(mem_rd_en), 0);
    check("fl.mem_wr", 32'(mem_wr_en), 0);
    tick();
    check("fl.wb_we", 32'(wb_reg_we), 0);
    drain();

    // write to x0 and dependent use of x0
    drive(1'b1, I_ADDI_X0); tick();
    check("x0.src2imm", 32'(ex_src2_imm), 1);
    drive(1'b1, I_ADD_X9); tick();
    check("x0.fwd1", 32'(ex_fwd1_sel), 2'b00);
    check("x0.fwd2", 32'(ex_fwd2_sel), 2'b00);
    drive(1'b0, I_NOP); tick();
    check("x0.wb_we", 32'(wb_reg_we), 0);
    drain();

    // illegal opcode, then reset with control in flight
    drive(1'b1, I_BAD); tick();
    check("ill.set", 32'(ex_illegal), 1);
    check("ill.alu", 32'(ex_alu_ctrl), 0);
    drive(1'b1, I_ADD_X3); tick();
    check("ill.clear", 32'(ex_illegal), 0);
    drive(1'b1, I_LW_X6); tick();
    rst = 1'b1;
    drive(1'b1, I_ADD_X3);
    tick();
    rst = 1'b0;
    drive(1'b0, I_NOP);
    check_all_bubble("midrst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
Pipelined control unit for the 5-stage RV32I core. Decodes the ID-stage instruction and carries its control fields through the ID/EX, EX/MEM and MEM/WB control registers. Drives the ALU operation, the source muxes in front of the ALU (operand select and forwarding), and the memory/writeback enables. Detects load-use hazards (stall) and taken control transfers (flush).

Parameters:
ALU_CTRL_W, 4, width of the ALU operation code
RADDR_W, 5, register address width

Ports:
clk  in  1  core clock
rst  in  1  synchronous, active-high reset
id_valid  in  1  IF/ID register holds a real instruction
id_instr  in  32  instruction in the ID stage
ex_branch_taken  in  1  EX-stage branch resolved taken, or JAL/JALR in EX
stall  out  1  hold PC and IF/ID; combinational
flush  out  1  kill IF/ID contents; combinational
ex_alu_ctrl  out  ALU_CTRL_W  ALU operation, registered in ID/EX
ex_src1_pc  out  1  ALU src1 = PC (AUIPC/JAL/JALR link)
ex_src2_imm  out  1  ALU src2 = immediate
ex_fwd1_sel  out  2  src1 forward: 00 regfile, 01 EX/MEM result, 10 MEM/WB result
ex_fwd2_sel  out  2  src2 forward, same encoding
ex_illegal  out  1  ID/EX holds an undecodable valid instruction
mem_rd_en  out  1  data-memory read, EX/MEM stage
mem_wr_en  out  1  data-memory write, EX/MEM stage
wb_reg_we  out  1  register-file write, MEM/WB stage
wb_rd  out  RADDR_W  writeback destination
wb_from_mem  out  1  writeback data from load (1) or ALU (0)

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high.
- Reset: all stage registers are cleared to a bubble. A bubble is: all enables 0, rd=0, rs1/rs2=0, alu_ctrl=ADD (0), selects 0, illegal 0. Consequently stall=0, flush=0 and all fwd sels are 00 in the cycle after reset.
- ALU codes: ADD 0, SUB 1, SLL 2, SLT 3, SLTU 4, XOR 5, SRL 6, SRA 7, OR 8, AND 9, PASSB 10.
- Opcode decode in ID:
  - R-type (0110011): uses funct3 and funct7[5] (SUB, SRA).
  - I-ALU (0010011): funct7[5] only distinguishes SRAI. Uses imm.
  - LOAD, STORE, JALR, AUIPC: ADD with imm.
  - LUI: PASSB with imm.
  - JAL and JALR: src1_pc=1 and link write.
  - BRANCH: SUB, no write.
  - Any other opcode: decoded as a bubble with illegal=1.
- rs1 is used by R, I-ALU, LOAD, STORE, BRANCH and JALR. rs2 is used by R, STORE and BRANCH. An unused rs field is recorded as 0.
- reg_we is forced to 0 whenever rd=0.
- ID/EX update each cycle, in priority order:
  1. rst → bubble.
  2. flush → bubble.
  3. stall → bubble.
  4. !id_valid → bubble.
  5. Otherwise → decoded fields.
- EX/MEM and MEM/WB shift unconditionally (never stalled). One cycle latency per stage.
- stall: asserted when the ID/EX entry is a load with rd≠0, and rd matches a used ID rs1 or rs2, and id_valid=1 and flush=0. Produces exactly one bubble per load-use pair.
- flush: equals ex_branch_taken. flush dominates stall when both would assert.
- Forwarding, src1 (src2 is identical using rs2):
  - Select 01 if the EX/MEM reg_we=1, its rd≠0 and its rd equals the ID/EX rs1.
  - Otherwise select 10 if the MEM/WB entry matches under the same conditions.
  - Otherwise select 00.
  - EX/MEM has priority over MEM/WB.
- Forwarding sels are combinational from registered state only (no input-to-output path).
- Reset asserted mid-operation: all in-flight control is discarded on that edge.

Decomposition:
- Package pipe_pkg holds:
  - opcode localparams;
  - the alu_op_e enum;
  - the fwd_sel_e enum;
  - the ctrl_t struct (reg_we, rd, rs1, rs2, mem_rd, mem_wr, src1_pc, src2_imm, alu_ctrl, illegal);
  - a CTRL_BUBBLE constant.
- Sub-module pipe_decode: purely combinational, id_instr → ctrl_t.

Test Plan:
- Reset, then `add x3,x1,x2` (0x002081B3), id_valid=1:
  - next cycle ex_alu_ctrl=0, ex_src2_imm=0;
  - 2 cycles later wb_reg_we=1, wb_rd=3.
- `sub x5,x3,x4` directly after `add x3`: ex_fwd1_sel=01 while sub is in EX. With one NOP between them: ex_fwd1_sel=10.
- `lw x6,0(x1)` then `add x7,x6,x2`:
  - stall=1 for exactly one cycle, bubble inserted;
  - add then sees ex_fwd1_sel=10;
  - mem_rd_en=1 then wb_from_mem=1 for the load.
- ex_branch_taken=1 while a load-use condition is also true: flush=1, stall=0, next ex_alu_ctrl=0 with every enable 0.
- Writes to x0 (`addi x0,x1,5`), then a dependent use of x0: wb_reg_we=0, and fwd sels stay 00.
- Opcode 0x7F, then rst asserted mid-stream:
  - ex_illegal=1 for one cycle;
  - after rst, every stage is a bubble and all outputs are at their reset values.
